// File: rtl/arm_pkg.sv
// Shared constants for the ARM execute-stage flag logic: condition-code
// encodings and the bit positions of N, Z, C and V inside an NZCV nibble.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit ARM
// condition field passes against a given NZCV value. Pure logic so the
// decode stage can reuse it unchanged.
module arm_cond_eval
    import arm_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = nzcv_i[FLG_N];
    assign flag_z = nzcv_i[FLG_Z];
    assign flag_c = nzcv_i[FLG_C];
    assign flag_v = nzcv_i[FLG_V];

    // Decode the condition field into a single pass bit.
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = flag_z;
            COND_NE: pass_o = !flag_z;
            COND_CS: pass_o = flag_c;
            COND_CC: pass_o = !flag_c;
            COND_MI: pass_o = flag_n;
            COND_PL: pass_o = !flag_n;
            COND_VS: pass_o = flag_v;
            COND_VC: pass_o = !flag_v;
            COND_HI: pass_o = flag_c & !flag_z;
            COND_LS: pass_o = !flag_c | flag_z;
            COND_GE: pass_o = (flag_n == flag_v);
            COND_LT: pass_o = (flag_n != flag_v);
            COND_GT: pass_o = !flag_z & (flag_n == flag_v);
            COND_LE: pass_o = flag_z | (flag_n != flag_v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_flags.sv
// Condition-flag stage of the execute datapath. Derives N/Z/C/V from the
// ALU result and adder/shifter carries, holds the architectural NZCV
// register, and registers a condition-pass bit evaluated against the
// next-state flags so a flag-setting instruction can be followed directly
// by a conditional one without a stall.
//
// Qualifier semantics: VALID qualifies only the flag update (together with
// SETF). CPASS is produced every cycle regardless of VALID; whoever consumes
// it must gate it with its own valid for the instruction in execute.
module arm_flags
    import arm_pkg::*;
#(
    parameter int    N      = 32,
    parameter bit    DPFLAG = 1'b1,
    parameter string GROUP  = "dpath1"
) (
    input  logic         CLK,
    input  logic         NRESET,
    input  logic [N-1:0] RES,
    input  logic         COUT,
    input  logic         OVF,
    input  logic         SHC,
    input  logic         LOGIC,
    input  logic         VALID,
    input  logic         SETF,
    input  logic         WFLAG_EN,
    input  logic [3:0]   WFLAGS,
    input  logic [3:0]   COND,
    output logic [3:0]   NZCV,
    output logic         CPASS
);

    // Placement hints for the layout flow; they carry no logic. The empty
    // block just gives the parameters a reference in elaboration.
    if (DPFLAG && (GROUP == "")) begin : g_unnamed_group
    end

    logic [3:0]   flags_q;
    logic [3:0]   flags_d;
    logic         cpass_q;
    logic         cpass_d;
    logic         upd;
    logic [N-1:0] res_g;
    logic         calc_n;
    logic         calc_z;
    logic         calc_c;
    logic         calc_v;

    // A result-driven update only happens for a valid, S-bit instruction.
    // The result is forced to zero otherwise so an undriven RES on an idle
    // cycle cannot leak unknowns into the flag path.
    assign upd   = VALID & SETF;
    assign res_g = upd ? RES : '0;

    // Flag derivation: reduction NOR covers any width, including widths
    // that do not split evenly into 4-input gate groups.
    assign calc_n = res_g[N-1];
    assign calc_z = ~|res_g;
    assign calc_c = LOGIC ? SHC : COUT;
    assign calc_v = LOGIC ? flags_q[FLG_V] : OVF;

    // Next-flag select: direct write beats a computed update, else hold.
    always_comb begin
        flags_d = flags_q;
        if (WFLAG_EN) begin
            flags_d = WFLAGS;
        end else if (upd) begin
            flags_d = {calc_n, calc_z, calc_c, calc_v};
        end
    end

    // Condition is checked against the bypassed next-state flags.
    arm_cond_eval u_cond_eval (
        .cond_i (COND),
        .nzcv_i (flags_d),
        .pass_o (cpass_d)
    );

    // Flag register and registered condition pass; reset clears both at once.
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            flags_q <= 4'b0000;
            cpass_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cpass_q <= cpass_d;
        end
    end

    assign NZCV  = flags_q;
    assign CPASS = cpass_q;

endmodule
